// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared state encoding and parameter defaults for the FIFO read arbiter
package fifo_ctrl_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_N_CONS = 4;
  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_STALL_MAX = 8;
  typedef enum logic [1:0] {IDLE, BURST, RELEASE} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin selector searching upward from last_id+1 with wrap
module rr_pick #(
  parameter int N = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_id,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] id,
  output logic            any
);
  logic [ID_W-1:0] idx;
  // first requester after last_id wins; the previous winner is considered last
  always_comb begin
    id = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 1; i <= N; i++) begin
      idx = ID_W'((int'(last_id) + i) % N);
      if (!any && req[idx]) begin
        any = 1'b1;
        id = idx;
      end
    end
    grant = any ? N'(1) << id : '0;
  end
endmodule

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: grants bursts of FIFO pops to consumers in round-robin order
module fifo_read_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_CONS = DEF_N_CONS,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int STALL_MAX = DEF_STALL_MAX,
  localparam int ID_W = $clog2(N_CONS)
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  r_empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_req,
  input  logic [N_CONS-1:0]     cons_req,
  input  logic [N_CONS-1:0]     cons_ready,
  output logic [N_CONS-1:0]     cons_grant,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ID_W-1:0]       out_id
);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int SW = $clog2(STALL_MAX + 1);
  state_t state, state_nx;
  logic [N_CONS-1:0] grant_nx, pick_grant;
  logic [ID_W-1:0] id_nx, last_id, last_nx, pick_id;
  logic [BW-1:0] beat, beat_nx;
  logic [SW-1:0] stall, stall_nx;
  logic pick_any;
  rr_pick #(.N(N_CONS)) u_pick (
    .req(cons_req),
    .last_id(last_id),
    .grant(pick_grant),
    .id(pick_id),
    .any(pick_any)
  );
  assign out_valid = state == BURST && !r_empty && !r_rst;
  assign r_req = out_valid && cons_ready[out_id] && cons_req[out_id];
  assign out_data = r_data;
  // next-state: grant in IDLE, count beats/stalls in BURST, rotate priority in RELEASE
  always_comb begin
    state_nx = state;
    grant_nx = cons_grant;
    id_nx = out_id;
    last_nx = last_id;
    beat_nx = beat;
    stall_nx = stall;
    case (state)
      IDLE: if (!r_empty && pick_any) begin
        state_nx = BURST;
        grant_nx = pick_grant;
        id_nx = pick_id;
      end
      BURST: begin
        beat_nx = r_req ? beat + BW'(1) : beat;
        stall_nx = r_empty ? stall + SW'(1) : '0;
        if ((r_req && beat_nx == BW'(BURST_LEN)) || !cons_req[out_id] || (r_empty && stall_nx == SW'(STALL_MAX))) begin
          state_nx = RELEASE;
          grant_nx = '0;
        end
      end
      RELEASE: begin
        state_nx = IDLE;
        last_nx = out_id;
        beat_nx = '0;
        stall_nx = '0;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state and grant registers; reset leaves consumer 0 with top priority
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state <= IDLE;
      cons_grant <= '0;
      out_id <= '0;
      last_id <= ID_W'(N_CONS - 1);
      beat <= '0;
      stall <= '0;
    end else begin
      state <= state_nx;
      cons_grant <= grant_nx;
      out_id <= id_nx;
      last_id <= last_nx;
      beat <= beat_nx;
      stall <= stall_nx;
    end
  end
endmodule
